// File: rtl/acl2_sample_display_if.sv
// Bundle between the sample source/operator side and the display block.
// master drives samples and axis select; slave returns display state.
interface acl2_sample_display_if;
  logic [7:0] BYTE_DATA;
  logic       BYTE_VALID;
  logic [1:0] AXIS_TAG;
  logic [1:0] DISPLAY_AXIS;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic [2:0] AXIS_LED;
  logic       BUSY;
  logic       OVERRUN;

  modport master (
    output BYTE_DATA, BYTE_VALID,
    output AXIS_TAG, DISPLAY_AXIS,
    input  SEG, AN, AXIS_LED,
    input  BUSY, OVERRUN
  );

  modport slave (
    input  BYTE_DATA, BYTE_VALID,
    input  AXIS_TAG, DISPLAY_AXIS,
    output SEG, AN, AXIS_LED,
    output BUSY, OVERRUN
  );
endinterface

// File: rtl/acl2_sample_display.sv
// Filters one accelerometer axis, converts to sign+3 BCD digits
// (bit-serial double-dabble) and scans a 4-digit active-low display.
// Ports: CLK, RST_N (async low), bus (slave modport: sample in,
// SEG/AN/AXIS_LED/BUSY/OVERRUN out).
module acl2_sample_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic CLK,
  input logic RST_N,
  acl2_sample_display_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] RMAX = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  logic [1:0]    state_q, state_d;
  logic          sign_q, sign_d;
  logic [7:0]    mag_q, mag_d;
  logic [1:0]    tag_q, tag_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          dsign_q, dsign_d;
  logic [3:0]    dh_q, dh_d;
  logic [3:0]    dt_q, dt_d;
  logic [3:0]    do_q, do_d;
  logic [2:0]    led_q, led_d;
  logic [CW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;

  logic          accept;
  logic [11:0]   adj;
  logic [19:0]   sh;

  function automatic logic [3:0] dd(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign accept = bus.BYTE_VALID
               && (bus.AXIS_TAG == bus.DISPLAY_AXIS)
               && (bus.AXIS_TAG != 2'd3);

  assign adj = {dd(bcd_q[11:8]), dd(bcd_q[7:4]),
                dd(bcd_q[3:0])};
  assign sh  = {adj, mag_q} << 1;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    tag_d   = tag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dsign_d = dsign_q;
    dh_d    = dh_q;
    dt_d    = dt_q;
    do_d    = do_q;
    led_d   = led_q;
    // Any accepted byte arriving outside IDLE is lost.
    ovr_d   = ovr_q | (accept && (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sign_d  = bus.BYTE_DATA[7];
          mag_d   = bus.BYTE_DATA[7]
                  ? (~bus.BYTE_DATA + 8'd1)
                  : bus.BYTE_DATA;
          tag_d   = bus.AXIS_TAG;
          bcd_d   = '0;
          cnt_d   = 3'd7;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = sh[19:8];
        mag_d = sh[7:0];
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        dsign_d = sign_q;
        dh_d    = bcd_q[11:8];
        dt_d    = bcd_q[7:4];
        do_d    = bcd_q[3:0];
        led_d   = 3'(1 << tag_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RMAX) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      tag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      dsign_q <= 1'b0;
      dh_q    <= '0;
      dt_q    <= '0;
      do_q    <= '0;
      led_q   <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      tag_q   <= tag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      dsign_q <= dsign_d;
      dh_q    <= dh_d;
      dt_q    <= dt_d;
      do_q    <= do_d;
      led_q   <= led_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
    end
  end

  // Digit mux is purely combinational so AN and SEG switch together.
  always_comb begin
    bus.SEG = SEG_BLANK;
    unique case (idx_q)
      2'd0: bus.SEG = seg7(do_q);
      2'd1: bus.SEG = (dh_q == 4'd0 && dt_q == 4'd0)
                    ? SEG_BLANK : seg7(dt_q);
      2'd2: bus.SEG = (dh_q == 4'd0)
                    ? SEG_BLANK : seg7(dh_q);
      2'd3: bus.SEG = dsign_q ? SEG_MINUS : SEG_BLANK;
      default: bus.SEG = SEG_BLANK;
    endcase
  end

  assign bus.AN       = ~(4'b0001 << idx_q);
  assign bus.AXIS_LED = led_q;
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.OVERRUN  = ovr_q;

endmodule

// File: tb/tb_acl2_sample_display.sv
// Scoreboard bench: stimulus queues expected display results,
// a monitor scans the display after each BUSY fall and compares.
module tb_acl2_sample_display;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] M  = 7'b0111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;

  typedef struct packed {
    logic [3:0][6:0] s;
    logic [2:0]      led;
    logic            ov;
    logic [7:0]      blen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic mon_act = 1'b0;
  exp_t sbq[$];

  acl2_sample_display_if bus();

  acl2_sample_display #(.REFRESH_DIV(4)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string      name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic exp_t mk(
    input logic [6:0] d3, input logic [6:0] d2,
    input logic [6:0] d1, input logic [6:0] d0,
    input logic [2:0] led, input logic ov,
    input logic [7:0] blen
  );
    exp_t e;
    e.s    = {d3, d2, d1, d0};
    e.led  = led;
    e.ov   = ov;
    e.blen = blen;
    return e;
  endfunction

  task automatic strobe(
    input logic [7:0] d, input logic [1:0] t
  );
    @(negedge clk);
    bus.BYTE_DATA  = d;
    bus.AXIS_TAG   = t;
    bus.BYTE_VALID = 1'b1;
    @(negedge clk);
    bus.BYTE_VALID = 1'b0;
  endtask

  // Monitor
  initial begin
    logic       pb;
    int         bl;
    exp_t       e;
    logic [6:0] got [4];
    logic [3:0] seen;
    pb = 1'b0;
    bl = 0;
    forever begin
      @(negedge clk);
      if (bus.BUSY) bl++;
      if (pb && !bus.BUSY) begin
        mon_act = 1'b1;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got busy fall expected none");
        end else begin
          e = sbq.pop_front();
          chk("overrun", 32'(bus.OVERRUN), 32'(e.ov));
          chk("axis_led", 32'(bus.AXIS_LED), 32'(e.led));
          if (e.blen != 0)
            chk("busy_len", 32'(bl), 32'(e.blen));
          seen = '0;
          for (int i = 0; i < 4; i++) got[i] = B;
          for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 4; i++)
              if (bus.AN == ~(4'b0001 << i)) begin
                got[i]  = bus.SEG;
                seen[i] = 1'b1;
              end
            @(negedge clk);
          end
          chk("digits_seen", 32'(seen), 32'hF);
          for (int i = 0; i < 4; i++)
            chk($sformatf("digit%0d", i),
                32'(got[i]), 32'(e.s[i]));
        end
        mon_act = 1'b0;
        bl = 0;
      end
      if (!bus.BUSY) bl = 0;
      pb = bus.BUSY;
    end
  end

  // Stimulus
  initial begin
    logic [3:0] an_exp [4];
    logic [6:0] sg_exp [4];
    int to;
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_exp = '{D0, B, B, B};
    bus.BYTE_DATA    = '0;
    bus.BYTE_VALID   = 1'b0;
    bus.AXIS_TAG     = '0;
    bus.DISPLAY_AXIS = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.AN), 32'h E);
    chk("rst_seg", 32'(bus.SEG), 32'(D0));
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("scan_an%0d", i),
          32'(bus.AN), 32'(an_exp[i]));
      chk($sformatf("scan_seg%0d", i),
          32'(bus.SEG), 32'(sg_exp[i]));
      repeat (4) @(negedge clk);
    end
    chk("rst_led", 32'(bus.AXIS_LED), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);

    bus.DISPLAY_AXIS = 2'd0;
    sbq.push_back(mk(B, D1, D2, D7, 3'b001, 1'b0, 8'd9));
    strobe(8'h7F, 2'd0);
    repeat (40) @(negedge clk);

    bus.DISPLAY_AXIS = 2'd2;
    sbq.push_back(mk(M, D1, D2, D8, 3'b100, 1'b0, 8'd9));
    strobe(8'h80, 2'd2);
    repeat (40) @(negedge clk);
    sbq.push_back(mk(M, B, D1, D0, 3'b100, 1'b0, 8'd9));
    strobe(8'hF6, 2'd2);
    repeat (40) @(negedge clk);

    bus.DISPLAY_AXIS = 2'd1;
    strobe(8'h05, 2'd0);
    strobe(8'h22, 2'd3);
    repeat (12) @(negedge clk);
    chk("ign_busy", 32'(bus.BUSY), 32'h0);
    chk("ign_ovr", 32'(bus.OVERRUN), 32'h0);
    chk("ign_led", 32'(bus.AXIS_LED), 32'h4);

    bus.DISPLAY_AXIS = 2'd0;
    sbq.push_back(mk(B, D1, D0, D0, 3'b001, 1'b1, 8'd9));
    strobe(8'h64, 2'd0);
    @(negedge clk);
    strobe(8'h01, 2'd0);
    repeat (40) @(negedge clk);

    sbq.push_back(mk(B, B, B, D0, 3'b000, 1'b0, 8'd0));
    strobe(8'h7F, 2'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.BUSY), 32'h0);
    chk("mid_ovr", 32'(bus.OVERRUN), 32'h0);
    chk("mid_an", 32'(bus.AN), 32'hE);
    chk("mid_seg", 32'(bus.SEG), 32'(D0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    sbq.push_back(mk(B, B, B, D0, 3'b001, 1'b0, 8'd9));
    strobe(8'h00, 2'd0);

    to = 0;
    while ((sbq.size() != 0 || mon_act || bus.BUSY)
           && to < 400) begin
      @(negedge clk);
      to++;
    end
    repeat (2) @(negedge clk);
    while (mon_act && to < 400) begin
      @(negedge clk);
      to++;
    end
    if (to >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
